intp_ctrl: RTL and testbench
============================

Name: intp_ctrl

Overview:
- Priority interrupt controller with an APB-style register slave.
- Software programs one priority value per peripheral through the APB port.
- The controller watches `intp_active_i`, selects the highest-priority pending line, and presents its index to the processor with `intp_valid_o`.
- It holds that request until the processor pulses `intp_serviced_i`, then arbitrates again.

Parameters:
- NUM_OF_PERIPHERALS, 16, number of interrupt lines and priority registers.
- ADDR_WIDTH, 4, APB address width; equals clog2(NUM_OF_PERIPHERALS).
- DATA_WIDTH, 4, width of priority values, `prdata`/`pwdata`, and the serviced index.

Ports:
- pclk_i  in  1  clock; all logic on rising edge.
- prst_i  in  1  asynchronous active-low reset.
- paddr_i  in  ADDR_WIDTH  register index (peripheral number).
- pwrite_i  in  1  1 = write, 0 = read.
- pwdata_i  in  DATA_WIDTH  write data (priority value).
- penable_i  in  1  access phase of a transfer.
- prdata_o  out  DATA_WIDTH  read data.
- pready_o  out  1  transfer complete.
- perror_o  out  1  transfer error.
- intp_active_i  in  NUM_OF_PERIPHERALS  pending interrupt lines, level, bit i = peripheral i.
- intp_serviced_i  in  1  processor pulse: current interrupt handled.
- intp_valid_o  out  1  an interrupt is presented for service.
- intp_to_service_o  out  DATA_WIDTH  index of the peripheral being presented.

Behaviour:
- Reset (prst_i=0, asynchronous):
  - all priority registers = 0;
  - FSM = IDLE;
  - intp_valid_o = 0, intp_to_service_o = 0.
  - Reset mid-service drops intp_valid_o immediately.
- APB slave, zero wait states:
  - pready_o = penable_i (combinational).
  - A transfer completes on the rising edge where penable_i=1.
  - Write: prio[paddr_i] <= pwdata_i.
  - Read: prdata_o = prio[paddr_i] combinationally while penable_i=1 and pwrite_i=0; otherwise prdata_o = 0.
- Address range:
  - paddr_i >= NUM_OF_PERIPHERALS sets perror_o = 1 during penable_i, with no register update and prdata_o = 0.
  - perror_o = 0 otherwise.
  - This case is unreachable at default parameters.
- Priority rule:
  - Larger numeric priority value wins.
  - On equal priorities, the lower peripheral index wins.
  - Only lines with intp_active_i[i] = 1 compete.
- FSM states IDLE and WAIT_SERVICE:
  - IDLE:
    - If |intp_active_i at the rising edge: latch the winning index into intp_to_service_o, set intp_valid_o <= 1, and go to WAIT_SERVICE.
    - Otherwise stay in IDLE with intp_valid_o = 0.
    - intp_serviced_i is ignored in IDLE.
  - WAIT_SERVICE:
    - intp_to_service_o is frozen, even if intp_active_i or priorities change.
    - On a rising edge with intp_serviced_i = 1: intp_valid_o <= 0 and go to IDLE.
- Re-arbitration timing:
  - intp_valid_o is low for at least one cycle between consecutive services, so each service produces a distinct rising edge.
  - Re-arbitration uses intp_active_i as sampled in IDLE.
  - The processor clears the serviced line before or together with its intp_serviced_i pulse.
- Latency:
  - intp_valid_o rises 1 cycle after a line becomes active in IDLE.
  - intp_valid_o falls 1 cycle after intp_serviced_i is sampled.
  - The next interrupt is presented 2 cycles after intp_serviced_i.
- Register access during service:
  - APB writes are accepted in any FSM state.
  - New priorities affect only the next arbitration.

Decomposition:
- Shared package intp_ctrl_pkg:
  - FSM state typedef (IDLE, WAIT_SERVICE);
  - default parameter constants.
- One combinational sub-module, intp_prio_arbiter:
  - inputs: active vector and the flattened priority array;
  - output: winner index and any-active flag;
  - implements the max-priority / lowest-index tie-break rule.
- intp_ctrl holds the APB register file and the FSM.

Test Plan:
- Reset check: assert prst_i=0 mid-clock -> intp_valid_o=0, intp_to_service_o=0, all 16 prio reads return 0.
- Register write/read: write prio[i] = 15-i for i = 0..15, read back each -> prdata_o = 15-i, pready_o=1 on every access, perror_o=0.
- Priority order: with prio[i] = 15-i, set intp_active_i = 16'hA5A5 and pulse intp_serviced_i, clearing the served bit, 3 cycles after each intp_valid_o rise -> services in order 0, 2, 5, 7, 8, 10, 13, 15, then intp_valid_o stays 0.
- Tie-break: all prio = 0, intp_active_i = 16'h0012 -> index 1 served first, then index 4.
- Freeze in service: while serving index 3 (prio 12), raise line 9 with prio 15 -> intp_to_service_o stays 3 until serviced, then 9 is presented 2 cycles after the pulse.
- Reset mid-service: intp_valid_o=1, assert reset -> intp_valid_o=0 asynchronously; after release with lines still active and prio=0 -> lowest active index is presented 1 cycle later.

Source files
------------

// File: rtl/intp_ctrl_pkg.sv
// Shared types and default sizing for the priority interrupt controller.
package intp_ctrl_pkg;

  localparam int DEF_NUM_OF_PERIPHERALS = 16;
  localparam int DEF_ADDR_WIDTH         = 4;
  localparam int DEF_DATA_WIDTH         = 4;

  typedef enum logic {
    IDLE         = 1'b0,
    WAIT_SERVICE = 1'b1
  } intp_state_t;

endpackage

// File: rtl/intp_prio_arbiter.sv
// Combinational max-priority selector; equal priorities resolve to the lowest index.
module intp_prio_arbiter
  import intp_ctrl_pkg::*;
#(
  parameter int NUM_OF_PERIPHERALS = DEF_NUM_OF_PERIPHERALS,
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH
) (
  input  logic [NUM_OF_PERIPHERALS-1:0]            active,
  input  logic [NUM_OF_PERIPHERALS*DATA_WIDTH-1:0] prio_flat,
  output logic [DATA_WIDTH-1:0]                    winner_idx,
  output logic                                     any_active
);

  logic [DATA_WIDTH-1:0] prio [NUM_OF_PERIPHERALS];
  logic [DATA_WIDTH-1:0] best_prio;

  generate
    for (genvar gi = 0; gi < NUM_OF_PERIPHERALS; gi++) begin : g_unpack
      assign prio[gi] = prio_flat[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Ascending scan with strict '>' so an equal later candidate never displaces an earlier one.
  always_comb begin
    best_prio  = '0;
    winner_idx = '0;
    any_active = 1'b0;
    for (int i = 0; i < NUM_OF_PERIPHERALS; i++) begin
      if (active[i] && (!any_active || (prio[i] > best_prio))) begin
        best_prio  = prio[i];
        winner_idx = DATA_WIDTH'(i);
        any_active = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intp_ctrl.sv
// Priority interrupt controller: APB priority register file plus a present/await-service FSM.
module intp_ctrl
  import intp_ctrl_pkg::*;
#(
  parameter int NUM_OF_PERIPHERALS = DEF_NUM_OF_PERIPHERALS,
  parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH
) (
  input  logic                          pclk_i,
  input  logic                          prst_i,
  input  logic [ADDR_WIDTH-1:0]         paddr_i,
  input  logic                          pwrite_i,
  input  logic [DATA_WIDTH-1:0]         pwdata_i,
  input  logic                          penable_i,
  output logic [DATA_WIDTH-1:0]         prdata_o,
  output logic                          pready_o,
  output logic                          perror_o,
  input  logic [NUM_OF_PERIPHERALS-1:0] intp_active_i,
  input  logic                          intp_serviced_i,
  output logic                          intp_valid_o,
  output logic [DATA_WIDTH-1:0]         intp_to_service_o
);

  logic [DATA_WIDTH-1:0]                    prio_reg [NUM_OF_PERIPHERALS];
  logic [NUM_OF_PERIPHERALS*DATA_WIDTH-1:0] prio_flat;
  logic                                     addr_ok;

  intp_state_t           state_reg, state_next;
  logic                  valid_reg, valid_next;
  logic [DATA_WIDTH-1:0] idx_reg, idx_next;
  logic [DATA_WIDTH-1:0] winner_idx;
  logic                  any_active;

  // Address checking only exists when the address space is larger than the register file.
  generate
    if ((2 ** ADDR_WIDTH) > NUM_OF_PERIPHERALS) begin : g_addr_chk
      assign addr_ok = (32'(paddr_i) < 32'(NUM_OF_PERIPHERALS));
    end else begin : g_addr_full
      assign addr_ok = 1'b1;
    end
  endgenerate

  assign pready_o = penable_i;
  assign perror_o = penable_i & ~addr_ok;
  assign prdata_o = (penable_i && !pwrite_i && addr_ok) ? prio_reg[paddr_i] : '0;

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      for (int i = 0; i < NUM_OF_PERIPHERALS; i++) begin
        prio_reg[i] <= '0;
      end
    end else if (penable_i && pwrite_i && addr_ok) begin
      prio_reg[paddr_i] <= pwdata_i;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_OF_PERIPHERALS; gi++) begin : g_flatten
      assign prio_flat[gi*DATA_WIDTH +: DATA_WIDTH] = prio_reg[gi];
    end
  endgenerate

  intp_prio_arbiter #(
    .NUM_OF_PERIPHERALS (NUM_OF_PERIPHERALS),
    .DATA_WIDTH         (DATA_WIDTH)
  ) u_arbiter (
    .active     (intp_active_i),
    .prio_flat  (prio_flat),
    .winner_idx (winner_idx),
    .any_active (any_active)
  );

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      idx_reg   <= idx_next;
    end
  end

  // The index is only loaded from IDLE, so it stays frozen for the whole service.
  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (any_active) begin
          idx_next   = winner_idx;
          valid_next = 1'b1;
          state_next = WAIT_SERVICE;
        end else begin
          valid_next = 1'b0;
        end
      end
      WAIT_SERVICE: begin
        if (intp_serviced_i) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign intp_valid_o      = valid_reg;
  assign intp_to_service_o = idx_reg;

endmodule

// File: tb/tb_intp_ctrl.sv
// Directed bench for intp_ctrl: register access, arbitration order, freeze and reset behaviour.
module tb_intp_ctrl;

  logic        pclk_i = 1'b0;
  logic        prst_i;
  logic [3:0]  paddr_i;
  logic        pwrite_i;
  logic [3:0]  pwdata_i;
  logic        penable_i;
  logic [3:0]  prdata_o;
  logic        pready_o;
  logic        perror_o;
  logic [15:0] intp_active_i;
  logic        intp_serviced_i;
  logic        intp_valid_o;
  logic [3:0]  intp_to_service_o;

  int tests_run    = 0;
  int tests_failed = 0;

  intp_ctrl dut (
    .pclk_i            (pclk_i),
    .prst_i            (prst_i),
    .paddr_i           (paddr_i),
    .pwrite_i          (pwrite_i),
    .pwdata_i          (pwdata_i),
    .penable_i         (penable_i),
    .prdata_o          (prdata_o),
    .pready_o          (pready_o),
    .perror_o          (perror_o),
    .intp_active_i     (intp_active_i),
    .intp_serviced_i   (intp_serviced_i),
    .intp_valid_o      (intp_valid_o),
    .intp_to_service_o (intp_to_service_o)
  );

  always #5 pclk_i = ~pclk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion before 200000");
    $fatal(1, "timeout");
  end

  task automatic apb_write(input logic [3:0] a, input logic [3:0] d,
                           output logic rdy, output logic err);
    @(negedge pclk_i);
    paddr_i = a; pwrite_i = 1'b1; pwdata_i = d; penable_i = 1'b0;
    @(negedge pclk_i);
    penable_i = 1'b1;
    #1;
    rdy = pready_o; err = perror_o;
    @(posedge pclk_i);
    #1;
    penable_i = 1'b0; pwrite_i = 1'b0;
    $display("[TB] apb write addr=%0d data=%0d ready=%0b error=%0b", a, d, rdy, err);
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [3:0] data,
                          output logic rdy, output logic err, output logic [3:0] idle_data,
                          output logic idle_rdy);
    @(negedge pclk_i);
    paddr_i = a; pwrite_i = 1'b0; penable_i = 1'b0;
    #1;
    idle_data = prdata_o; idle_rdy = pready_o;
    @(negedge pclk_i);
    penable_i = 1'b1;
    #1;
    data = prdata_o; rdy = pready_o; err = perror_o;
    @(posedge pclk_i);
    #1;
    penable_i = 1'b0;
    $display("[TB] apb read  addr=%0d data=%0d ready=%0b error=%0b", a, data, rdy, err);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge pclk_i);
      if (intp_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Processor model: handles for 3 cycles, clears the line together with the serviced pulse.
  task automatic pulse_service(input int idx);
    repeat (3) @(negedge pclk_i);
    intp_active_i[idx] = 1'b0;
    intp_serviced_i    = 1'b1;
    @(negedge pclk_i);
    intp_serviced_i    = 1'b0;
    $display("[TB] serviced index %0d", idx);
  endtask

  task automatic test_reset();
    logic r, e, ir;
    logic [3:0] d, id;
    tests_run++;
    if (intp_valid_o !== 1'b0 || intp_to_service_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_initial: valid=%0b idx=%0d, required valid=0 idx=0", intp_valid_o, intp_to_service_o);
    end
    @(negedge pclk_i);
    prst_i = 1'b1;
    apb_write(4'd0, 4'd7, r, e);
    @(negedge pclk_i);
    intp_active_i = 16'h0020;
    @(negedge pclk_i);
    tests_run++;
    if (intp_valid_o !== 1'b1 || intp_to_service_o !== 4'd5) begin
      tests_failed++;
      $display("FAIL reset_pre_present: valid=%0b idx=%0d, required valid=1 idx=5", intp_valid_o, intp_to_service_o);
    end
    @(posedge pclk_i);
    #3;
    prst_i = 1'b0;
    #1;
    tests_run++;
    if (intp_valid_o !== 1'b0 || intp_to_service_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_async: valid=%0b idx=%0d, required valid=0 idx=0", intp_valid_o, intp_to_service_o);
    end
    intp_active_i = 16'h0000;
    @(negedge pclk_i);
    prst_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      apb_read(4'(i), d, r, e, id, ir);
      tests_run++;
      if (d !== 4'd0) begin
        tests_failed++;
        $display("FAIL reset_prio_read[%0d]: read %0d, required 0", i, d);
      end
    end
  endtask

  task automatic test_register_rw();
    logic r, e, ir;
    logic [3:0] d, id;
    for (int i = 0; i < 16; i++) begin
      apb_write(4'(i), 4'(15 - i), r, e);
      tests_run++;
      if (r !== 1'b1 || e !== 1'b0) begin
        tests_failed++;
        $display("FAIL write_handshake[%0d]: ready=%0b error=%0b, required ready=1 error=0", i, r, e);
      end
    end
    for (int i = 0; i < 16; i++) begin
      apb_read(4'(i), d, r, e, id, ir);
      tests_run++;
      if (d !== 4'(15 - i) || r !== 1'b1 || e !== 1'b0) begin
        tests_failed++;
        $display("FAIL read_back[%0d]: data=%0d ready=%0b error=%0b, required data=%0d ready=1 error=0",
                 i, d, r, e, 15 - i);
      end
      tests_run++;
      if (id !== 4'd0 || ir !== 1'b0) begin
        tests_failed++;
        $display("FAIL read_setup_idle[%0d]: data=%0d ready=%0b, required data=0 ready=0", i, id, ir);
      end
    end
  endtask

  task automatic test_priority_order();
    int  exp_order [8];
    bit  ok;
    bit  seen;
    exp_order = '{0, 2, 5, 7, 8, 10, 13, 15};
    @(negedge pclk_i);
    intp_active_i = 16'hA5A5;
    for (int k = 0; k < 8; k++) begin
      wait_valid(ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL order_valid[%0d]: valid never rose, required valid=1", k);
      end
      tests_run++;
      if (intp_to_service_o !== 4'(exp_order[k])) begin
        tests_failed++;
        $display("FAIL order_index[%0d]: idx=%0d, required %0d", k, intp_to_service_o, exp_order[k]);
      end
      $display("[TB] presented index %0d (expected %0d)", intp_to_service_o, exp_order[k]);
      pulse_service(exp_order[k]);
      tests_run++;
      if (intp_valid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL order_drop[%0d]: valid=%0b, required 0", k, intp_valid_o);
      end
    end
    seen = 1'b0;
    repeat (5) begin
      @(negedge pclk_i);
      if (intp_valid_o !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL order_quiet: valid rose with no active lines, required 0");
    end
  endtask

  task automatic test_freeze();
    logic r, e;
    bit   ok;
    @(negedge pclk_i);
    intp_active_i = 16'h0008;
    wait_valid(ok);
    tests_run++;
    if (!ok || intp_to_service_o !== 4'd3) begin
      tests_failed++;
      $display("FAIL freeze_first: valid=%0b idx=%0d, required valid=1 idx=3", intp_valid_o, intp_to_service_o);
    end
    intp_active_i[9] = 1'b1;
    apb_write(4'd9, 4'd15, r, e);
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk_i);
      tests_run++;
      if (intp_valid_o !== 1'b1 || intp_to_service_o !== 4'd3) begin
        tests_failed++;
        $display("FAIL freeze_hold[%0d]: valid=%0b idx=%0d, required valid=1 idx=3", c, intp_valid_o, intp_to_service_o);
      end
    end
    intp_active_i[3] = 1'b0;
    intp_serviced_i  = 1'b1;
    @(negedge pclk_i);
    intp_serviced_i  = 1'b0;
    tests_run++;
    if (intp_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL freeze_gap: valid=%0b, required 0", intp_valid_o);
    end
    @(negedge pclk_i);
    tests_run++;
    if (intp_valid_o !== 1'b1 || intp_to_service_o !== 4'd9) begin
      tests_failed++;
      $display("FAIL freeze_next: valid=%0b idx=%0d, required valid=1 idx=9", intp_valid_o, intp_to_service_o);
    end
    $display("[TB] freeze: presented index %0d after service of 3", intp_to_service_o);
    pulse_service(9);
  endtask

  task automatic test_tie_break();
    logic r, e;
    bit   ok;
    for (int i = 0; i < 16; i++) apb_write(4'(i), 4'd0, r, e);
    @(negedge pclk_i);
    intp_active_i = 16'h0012;
    @(negedge pclk_i);
    tests_run++;
    if (intp_valid_o !== 1'b1 || intp_to_service_o !== 4'd1) begin
      tests_failed++;
      $display("FAIL tie_first: valid=%0b idx=%0d, required valid=1 idx=1", intp_valid_o, intp_to_service_o);
    end
    pulse_service(1);
    wait_valid(ok);
    tests_run++;
    if (!ok || intp_to_service_o !== 4'd4) begin
      tests_failed++;
      $display("FAIL tie_second: valid=%0b idx=%0d, required valid=1 idx=4", intp_valid_o, intp_to_service_o);
    end
    pulse_service(4);
  endtask

  task automatic test_reset_mid_service();
    logic r, e;
    bit   ok;
    apb_write(4'd6, 4'd9, r, e);
    @(negedge pclk_i);
    intp_active_i = 16'h0060;
    wait_valid(ok);
    tests_run++;
    if (!ok || intp_to_service_o !== 4'd6) begin
      tests_failed++;
      $display("FAIL midrst_pre: valid=%0b idx=%0d, required valid=1 idx=6", intp_valid_o, intp_to_service_o);
    end
    @(posedge pclk_i);
    #3;
    prst_i = 1'b0;
    #1;
    tests_run++;
    if (intp_valid_o !== 1'b0 || intp_to_service_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL midrst_drop: valid=%0b idx=%0d, required valid=0 idx=0", intp_valid_o, intp_to_service_o);
    end
    @(negedge pclk_i);
    prst_i = 1'b1;
    @(negedge pclk_i);
    tests_run++;
    if (intp_valid_o !== 1'b1 || intp_to_service_o !== 4'd5) begin
      tests_failed++;
      $display("FAIL midrst_after: valid=%0b idx=%0d, required valid=1 idx=5", intp_valid_o, intp_to_service_o);
    end
    $display("[TB] after mid-service reset presented index %0d", intp_to_service_o);
    intp_active_i = 16'h0000;
    pulse_service(5);
  endtask

  initial begin
    prst_i          = 1'b0;
    paddr_i         = '0;
    pwrite_i        = 1'b0;
    pwdata_i        = '0;
    penable_i       = 1'b0;
    intp_active_i   = '0;
    intp_serviced_i = 1'b0;
    repeat (2) @(negedge pclk_i);
    test_reset();
    test_register_rw();
    test_priority_order();
    test_freeze();
    test_tie_break();
    test_reset_mid_service();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
